// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared definitions for the bus arbiter slice: arbiter state
//             encoding and the index-width helper used to size owner/last.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    // Width of an index into n sources; never below one bit so that a
    // single-requester build still has a usable owner port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin selector. Searches the request vector
//             starting just after the most recent winner, wrapping at COUNT.
//  Ports    : i_req     [COUNT] request vector
//             i_last    [IW]    index of the previous winner
//             o_winner  [IW]    first requester found after i_last
//             o_any_req         at least one request is present
//  Revision : 1.0  initial release
// ============================================================================
module rr_picker
    import bus_pkg::*;
#(
    parameter int  COUNT = 4,
    localparam int IW    = idx_width(COUNT)
) (
    input  logic [COUNT-1:0] i_req,
    input  logic [IW-1:0]    i_last,
    output logic [IW-1:0]    o_winner,
    output logic             o_any_req
);

    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_winner;
    logic          w_found;

    // k runs 1..COUNT so the previous winner itself is tried last.
    always_comb begin
        w_idx    = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= COUNT; k++) begin
            w_idx = IW'((int'(i_last) + k) % COUNT);
            if (!w_found && i_req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign o_winner  = w_winner;
    assign o_any_req = w_found;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin sequencer for the shared internal bus. Issues a
//             one-hot enable to one requester at a time, limits hold time to
//             MAX_HOLD cycles (0 = unlimited) and inserts one dead cycle
//             between consecutive owners.
//  Ports    : clk      system clock, rising edge
//             reset    asynchronous active-high reset
//             req      [COUNT] per-requester request, held for the transfer
//             enable   [COUNT] one-hot grant or zero (to bus block enable)
//             owner    [IW]    index of current owner, valid when enable!=0
//             busy             arbiter is not idle
//             timeout          one-cycle pulse when an owner is preempted
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int  COUNT    = 4,
    parameter int  MAX_HOLD = 8,
    localparam int IW       = idx_width(COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COUNT-1:0] req,
    output logic [COUNT-1:0] enable,
    output logic [IW-1:0]    owner,
    output logic             busy,
    output logic             timeout
);

    // Counter must represent MAX_HOLD itself; kept one bit wide when unused.
    localparam int            HW         = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] c_max_hold = HW'(MAX_HOLD);

    logic [1:0]       r_state;
    logic [COUNT-1:0] r_enable;
    logic [IW-1:0]    r_owner;
    logic             r_busy;
    logic             r_timeout;
    logic [HW-1:0]    r_hold_cnt;
    logic [IW-1:0]    r_last;

    logic [1:0]       w_state_nxt;
    logic [COUNT-1:0] w_enable_nxt;
    logic [IW-1:0]    w_owner_nxt;
    logic             w_timeout_nxt;
    logic [HW-1:0]    w_hold_nxt;
    logic [IW-1:0]    w_last_nxt;
    logic [IW-1:0]    w_winner;
    logic             w_any_req;

    rr_picker #(
        .COUNT (COUNT)
    ) u_picker (
        .i_req     (req),
        .i_last    (r_last),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_enable   <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_last     <= IW'(COUNT - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_enable   <= w_enable_nxt;
            r_owner    <= w_owner_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_timeout  <= w_timeout_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last     <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enable_nxt  = r_enable;
        w_owner_nxt   = r_owner;
        w_timeout_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        w_last_nxt    = r_last;
        case (r_state)
            GRANT: begin
                if (!req[r_owner]) begin
                    w_enable_nxt = '0;
                    w_state_nxt  = TURN;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == c_max_hold)) begin
                    w_enable_nxt  = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = TURN;
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                // IDLE and TURN both arbitrate; TURN is the dead cycle itself.
                if (w_any_req) begin
                    w_state_nxt  = GRANT;
                    w_enable_nxt = COUNT'(1) << w_winner;
                    w_owner_nxt  = w_winner;
                    w_last_nxt   = w_winner;
                    w_hold_nxt   = HW'(1);
                end else begin
                    w_state_nxt  = IDLE;
                    w_enable_nxt = '0;
                end
            end
        endcase
    end

    assign enable  = r_enable;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign timeout = r_timeout;

    a_enable_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(enable));
    a_enable_in_grant : assert property (@(posedge clk) disable iff (reset)
        (enable != '0) |-> (r_state == GRANT));
    a_timeout_no_enable : assert property (@(posedge clk) disable iff (reset)
        timeout |-> (enable == '0));

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Scoreboard bench for bus_arbiter. A reference model of the
//             arbitration rules predicts the outputs after every clock edge;
//             a monitor compares the DUT outputs against those predictions.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int COUNT    = 4;
    localparam int MAX_HOLD = 8;

    logic             clk;
    logic             reset;
    logic [COUNT-1:0] req;
    logic [COUNT-1:0] enable;
    logic [1:0]       owner;
    logic             busy;
    logic             timeout;

    bus_arbiter #(
        .COUNT    (COUNT),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .enable  (enable),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [COUNT-1:0] en;
        int               own;
        bit               bsy;
        bit               to;
    } exp_t;

    exp_t q[$];
    int   n_checks;
    int   n_errors;
    bit   chk_en;

    // Reference model: who owns the bus (-1 = nobody), whether we are in the
    // mandatory gap after a grant, how long the owner has held, last winner.
    int m_owner;
    bit m_gap;
    int m_hold;
    int m_last;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gap   = 1'b0;
        m_hold  = 0;
        m_last  = COUNT - 1;
    endtask

    // Apply one clock edge worth of rules with request vector r.
    task automatic model_step(input logic [COUNT-1:0] r, output exp_t e);
        bit preempt;
        preempt = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
                m_owner = -1;
                m_gap   = 1'b1;
                preempt = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            m_gap = 1'b0;
            for (int k = 1; k <= COUNT; k++) begin
                int i;
                i = (m_last + k) % COUNT;
                if (m_owner < 0 && r[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_hold  = 1;
                end
            end
        end
        e.en  = (m_owner >= 0) ? (COUNT'(1) << m_owner) : '0;
        e.own = m_owner;
        e.bsy = (m_owner >= 0) || m_gap;
        e.to  = preempt;
    endtask

    // Drive one cycle of stimulus and queue the predicted outputs.
    task automatic cycle(input logic [COUNT-1:0] r);
        exp_t e;
        req = r;
        model_step(r, e);
        q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (chk_en && q.size() > 0) begin
            e = q.pop_front();
            chk("enable", int'(enable), int'(e.en));
            chk("busy", int'(busy), int'(e.bsy));
            chk("timeout", int'(timeout), int'(e.to));
            if (e.en != '0) chk("owner", int'(owner), e.own);
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        chk_en = 1'b0;
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        logic [COUNT-1:0] r;
        n_checks = 0;
        n_errors = 0;
        req      = '0;
        reset    = 1'b1;
        chk_en   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        chk("reset_enable", int'(enable), 0);
        chk("reset_owner", int'(owner), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk_en = 1'b1;

        // Quiet bus.
        repeat (5) cycle(4'b0000);

        // Single short transfer, release, dead cycle, idle.
        repeat (3) cycle(4'b0001);
        repeat (4) cycle(4'b0000);

        // Everyone requesting; each owner drops two cycles into its grant.
        for (int n = 0; n < 24; n++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold >= 2) r[m_owner] = 1'b0;
            cycle(r);
        end
        repeat (3) cycle(4'b0000);

        // Lone long requester: repeated preemption and re-grant.
        repeat (30) cycle(4'b0010);
        repeat (3) cycle(4'b0000);

        // Two long requesters alternate at MAX_HOLD.
        repeat (40) cycle(4'b0110);
        repeat (3) cycle(4'b0000);

        // Random traffic with sticky requests so timeouts also occur.
        r = '0;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < COUNT; b++) begin
                if (!r[b]) r[b] = ($urandom_range(0, 7) == 0);
                else       r[b] = ($urandom_range(0, 15) != 0);
            end
            cycle(r);
        end
        repeat (3) cycle(4'b0000);

        // Asynchronous reset in the middle of a grant to requester 2.
        do_reset();
        repeat (3) cycle(4'b0100);
        chk("pre_reset_enable", int'(enable), 4);
        reset  = 1'b1;
        chk_en = 1'b0;
        #1;
        chk("async_reset_enable", int'(enable), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_timeout", int'(timeout), 0);
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (4) cycle(4'b0100);
        repeat (3) cycle(4'b0000);

        // Priority restarts at index 0 after reset.
        do_reset();
        cycle(4'b0101);
        chk("priority_restart", int'(enable), 1);
        repeat (6) cycle(4'b0101);
        repeat (3) cycle(4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
